// File: rtl/lsu_data_mem_if.sv
// ---------------------------------------------------------------------------
// lsu_data_mem_if
// Bus between the LSQ / writeback arbiter (master) and the data memory
// (slave).
//   st_*   : committed store, no backpressure; st_err pulses one cycle later
//            if the store was dropped.
//   ld_*   : load request, transfers on ld_valid && ld_ready.
//   flush  : kills every in-flight load and any load offered in the same cycle.
//   resp_* : load result, transfers on resp_valid && resp_ready.
// ---------------------------------------------------------------------------
interface lsu_data_mem_if #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5,
  parameter int PREG_W = 7
);
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [1:0]        st_size;
  logic [31:0]       st_data;
  logic              st_err;

  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [2:0]        ld_func3;
  logic [TAG_W-1:0]  ld_tag;
  logic [PREG_W-1:0] ld_pd;
  logic              flush;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic [PREG_W-1:0] resp_pd;
  logic              resp_err;

  modport master (
    output st_valid, st_addr, st_size, st_data,
    input  st_err,
    output ld_valid, ld_addr, ld_func3, ld_tag, ld_pd, flush,
    input  ld_ready,
    input  resp_valid, resp_data, resp_tag, resp_pd, resp_err,
    output resp_ready
  );

  modport slave (
    input  st_valid, st_addr, st_size, st_data,
    output st_err,
    input  ld_valid, ld_addr, ld_func3, ld_tag, ld_pd, flush,
    output ld_ready,
    output resp_valid, resp_data, resp_tag, resp_pd, resp_err,
    input  resp_ready
  );
endinterface

// File: rtl/lsu_data_mem.sv
// ---------------------------------------------------------------------------
// lsu_data_mem
// Byte-addressable little-endian data memory behind the LSQ. Executes
// committed stores (sb/sh/sw) and returns loads (lb/lh/lw/lbu/lhu) with
// their ROB tag and destination preg after LOAD_LAT cycles.
//
// Ports:
//   clk      : clock
//   reset_n  : synchronous active-low reset (pipeline only, memory kept)
//   bus      : lsu_data_mem_if.slave (store, load, flush and response)
//
// Handshake: a load transfers at a rising edge where ld_valid && ld_ready;
// a response transfers at a rising edge where resp_valid && resp_ready.
// While resp_valid && !resp_ready the whole pipeline freezes and the resp_*
// outputs hold. Stores have no handshake and are always taken.
// ---------------------------------------------------------------------------
module lsu_data_mem #(
  parameter int DEPTH_BYTES = 8192,
  parameter int ADDR_W      = 32,
  parameter int TAG_W       = 5,
  parameter int PREG_W      = 7,
  parameter int LOAD_LAT    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  lsu_data_mem_if.slave bus
);
  localparam int IW = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH_BYTES);
  localparam logic [IW:0]     DEPTH_I = (IW+1)'(DEPTH_BYTES);

  logic [7:0] mem [DEPTH_BYTES];

  // ---------------- store decode ----------------
  logic [2:0] st_nbytes;
  logic       st_bad;

  always_comb begin
    st_nbytes = 3'd0;
    case (bus.st_size)
      2'b00:   st_nbytes = 3'd1;
      2'b01:   st_nbytes = 3'd2;
      2'b10:   st_nbytes = 3'd4;
      default: st_nbytes = 3'd0;
    endcase
    // Range check is done one bit wider so addr+size cannot wrap.
    st_bad = (st_nbytes == 3'd0)
          || (bus.st_size == 2'b01 && bus.st_addr[0])
          || (bus.st_size == 2'b10 && bus.st_addr[1:0] != 2'b00)
          || (({1'b0, bus.st_addr} + (ADDR_W+1)'(st_nbytes)) > DEPTH_A);
  end

  // Memory array has no reset; writes happen at the accepting edge, so a
  // load sampled on the same edge still sees the old contents.
  always_ff @(posedge clk) begin
    if (bus.st_valid && !st_bad) begin
      for (int j = 0; j < 4; j++) begin
        if (3'(j) < st_nbytes) begin
          mem[bus.st_addr[IW-1:0] + IW'(j)] <= bus.st_data[8*j +: 8];
        end
      end
    end
  end

  // ---------------- load decode ----------------
  logic [2:0]  ld_nbytes;
  logic        ld_signed;
  logic        ld_fault;
  logic [IW:0] rd_idx;
  logic [7:0]  rd_b [4];
  logic [31:0] ld_word;

  always_comb begin
    ld_nbytes = 3'd0;
    ld_signed = 1'b0;
    case (bus.ld_func3)
      3'b000: begin ld_nbytes = 3'd1; ld_signed = 1'b1; end
      3'b001: begin ld_nbytes = 3'd2; ld_signed = 1'b1; end
      3'b010: begin ld_nbytes = 3'd4; end
      3'b100: begin ld_nbytes = 3'd1; end
      3'b101: begin ld_nbytes = 3'd2; end
      default: begin ld_nbytes = 3'd0; end
    endcase
    ld_fault = (ld_nbytes == 3'd0)
            || (ld_nbytes == 3'd2 && bus.ld_addr[0])
            || (ld_nbytes == 3'd4 && bus.ld_addr[1:0] != 2'b00)
            || (({1'b0, bus.ld_addr} + (ADDR_W+1)'(ld_nbytes)) > DEPTH_A);
  end

  // Fetch four consecutive bytes; bytes past the end of the array read as
  // zero so a narrow load at the top of memory never indexes out of range.
  always_comb begin
    rd_idx = '0;
    for (int j = 0; j < 4; j++) begin
      rd_idx  = {1'b0, bus.ld_addr[IW-1:0]} + (IW+1)'(j);
      rd_b[j] = (rd_idx < DEPTH_I) ? mem[rd_idx[IW-1:0]] : 8'h00;
    end
  end

  always_comb begin
    ld_word = 32'h0;
    if (!ld_fault) begin
      case (ld_nbytes)
        3'd1:    ld_word = {{24{ld_signed & rd_b[0][7]}}, rd_b[0]};
        3'd2:    ld_word = {{16{ld_signed & rd_b[1][7]}}, rd_b[1], rd_b[0]};
        default: ld_word = {rd_b[3], rd_b[2], rd_b[1], rd_b[0]};
      endcase
    end
  end

  // ---------------- load pipeline ----------------
  logic              p_valid [LOAD_LAT];
  logic [31:0]       p_data  [LOAD_LAT];
  logic [TAG_W-1:0]  p_tag   [LOAD_LAT];
  logic [PREG_W-1:0] p_pd    [LOAD_LAT];
  logic              p_err   [LOAD_LAT];
  logic              st_err_q;
  logic              stall;
  logic              accept;

  assign stall        = p_valid[LOAD_LAT-1] && !bus.resp_ready;
  assign bus.ld_ready = reset_n && !bus.flush && !stall;
  assign accept       = bus.ld_valid && bus.ld_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_err_q <= 1'b0;
      for (int i = 0; i < LOAD_LAT; i++) begin
        p_valid[i] <= 1'b0;
        p_data[i]  <= '0;
        p_tag[i]   <= '0;
        p_pd[i]    <= '0;
        p_err[i]   <= 1'b0;
      end
    end else begin
      st_err_q <= bus.st_valid && st_bad;
      if (bus.flush) begin
        // Flush beats both advance and stall; payload may go stale.
        for (int i = 0; i < LOAD_LAT; i++) p_valid[i] <= 1'b0;
      end else if (!stall) begin
        p_valid[0] <= accept;
        p_data[0]  <= accept ? ld_word : 32'h0;
        p_tag[0]   <= bus.ld_tag;
        p_pd[0]    <= bus.ld_pd;
        p_err[0]   <= accept && ld_fault;
        for (int i = 1; i < LOAD_LAT; i++) begin
          p_valid[i] <= p_valid[i-1];
          p_data[i]  <= p_data[i-1];
          p_tag[i]   <= p_tag[i-1];
          p_pd[i]    <= p_pd[i-1];
          p_err[i]   <= p_err[i-1];
        end
      end
    end
  end

  assign bus.st_err     = st_err_q;
  assign bus.resp_valid = p_valid[LOAD_LAT-1];
  assign bus.resp_data  = p_data[LOAD_LAT-1];
  assign bus.resp_tag   = p_tag[LOAD_LAT-1];
  assign bus.resp_pd    = p_pd[LOAD_LAT-1];
  assign bus.resp_err   = p_err[LOAD_LAT-1];
endmodule
